pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL provide port Clk  input  1  system clock; all state updates on rising edge.
REQ-002 The block SHALL provide port CLB  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL provide port LoadIR  input  1  controller request: transfer instruction at PC into IR.
REQ-004 The block SHALL provide ports IncPC and LoadPC  input  1 each  controller PC update strobes.
REQ-005 The block SHALL provide port SelPC  input  1  jump-target select: 1 = IR operand (immediate), 0 = RegData.
REQ-006 The block SHALL provide port RegData  input  4  register-file value used as a jump target.
REQ-007 The block SHALL provide ports MemReq (output, 1) and MemAddr (output, 4)  instruction-ROM read request and address.
REQ-008 The block SHALL provide ports MemValid (input, 1) and MemData (input, 8)  ROM response; MemData is valid in the MemValid cycle.
REQ-009 The block SHALL provide ports Opcode (output, 4) = IR[7:4] and Operand (output, 4) = IR[3:0]  feed to controller_fsm.
REQ-010 The block SHALL provide ports PC (output, 4) and IRValid (output, 1)  current program counter; IR holds a fetched instruction.

Function
REQ-011 PC update: LoadPC=1 SHALL load the SelPC-selected target; otherwise IncPC=1 SHALL load PC+1 mod 16 (15 wraps to 0). LoadPC SHALL win when both strobes are high.
REQ-012 Prefetch buffer: 8-bit data with a 4-bit tag. It SHALL count as a hit only when valid and tag == fetch address.
REQ-013 Fetch address: LoadAddr while a load is pending, else PC.
REQ-014 The FSM states SHALL be IDLE, FETCH and FULL.
REQ-015 IDLE SHALL transition to FETCH on the first clock after reset release, with MemReq=0 while in IDLE.
REQ-016 In FETCH, MemReq SHALL be 1 and MemAddr SHALL equal the fetch address latched on state entry. Both SHALL be held stable until MemValid.
REQ-017 FETCH + MemValid + (latched address == current fetch address) SHALL write the buffer, set the tag and move to FULL.
REQ-018 FETCH + MemValid + address mismatch (PC changed in flight) SHALL discard the data, stay in FETCH and issue a new request for the current fetch address on the next cycle.
REQ-019 In FULL, MemReq SHALL be 0. A fetch address change causing a miss SHALL invalidate the buffer and move to FETCH.
REQ-020 LoadIR on a buffer hit SHALL load IR on that edge and set IRValid=1, with 1-cycle latency. The buffer SHALL then be invalidated and the FSM SHALL move to FETCH.
REQ-021 LoadIR on a miss SHALL latch LoadAddr=PC, set Pending=1 and clear IRValid.
REQ-022 While Pending, the fill SHALL load IR directly, set IRValid=1, clear Pending and leave the buffer invalid (FSM to FETCH).
REQ-023 While IRValid=0, Opcode SHALL read 4'b0000 (NOP) and Operand SHALL read 4'b0000.
REQ-024 LoadIR while Pending SHALL re-latch LoadAddr=PC; the newest request SHALL win.
REQ-025 Simultaneous LoadIR and PC update SHALL use the pre-update PC for the IR load.

Reset
REQ-026 Asserting CLB low SHALL immediately force: PC=0, IR=8'h00, IRValid=0, MemReq=0, MemAddr=0, buffer invalid, Pending=0, FSM=IDLE.
REQ-027 Reset asserted mid-FETCH SHALL abandon the request. A MemValid arriving during or after reset without a fresh request SHALL be ignored.

Structure
REQ-028 The shared cpu_pkg SHALL hold the opcode constants (ADD 0001 ... HALT 1111), the instruction/PC/data widths (8/4/4) and the FSM state encodings.
REQ-029 The PC register and next-PC mux SHALL be a sub-module pc_register (inputs IncPC, LoadPC, SelPC, targets; output PC).

Verification
REQ-030 Reset release, ROM returns 8'h1A after 2 wait cycles, LoadIR on cycle 5 -> MemAddr=0, IR=8'h1A, Opcode=0001, Operand=1010, IRValid=1, PC unchanged.
REQ-031 PC=15 with IncPC pulse -> PC=0; next MemReq addresses 0.
REQ-032 LoadPC with SelPC=0 and RegData=4'h7 while a fetch of address 3 is in flight -> address-3 data discarded; new MemReq to address 7; buffer tag=7.
REQ-033 LoadPC and IncPC in the same cycle with SelPC=1 and Operand=4'h9 -> PC=9.
REQ-034 LoadIR on a miss at PC=4, IncPC in the same cycle -> PC=5, IRValid=0, Opcode=0000 until the address-4 fill, then IR=mem[4] and the next fetch targets address 5.
REQ-035 CLB pulsed low mid-FETCH with MemValid arriving 1 cycle later -> all outputs at reset values; the late response is not captured.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small 8-bit-instruction CPU:
//   - instruction / PC / data widths
//   - opcode constants (upper nibble of an instruction word)
//   - fetch-unit FSM state encoding
//   - pcIncr(): next sequential PC, wrapping 15 -> 0
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int INSTR_W = 8;
   localparam int PC_W    = 4;
   localparam int DATA_W  = 4;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b0110;
   localparam logic [3:0] OP_SHL  = 4'b0111;
   localparam logic [3:0] OP_SHR  = 4'b1000;
   localparam logic [3:0] OP_LDI  = 4'b1001;
   localparam logic [3:0] OP_LD   = 4'b1010;
   localparam logic [3:0] OP_ST   = 4'b1011;
   localparam logic [3:0] OP_MOV  = 4'b1100;
   localparam logic [3:0] OP_JMP  = 4'b1101;
   localparam logic [3:0] OP_JZ   = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } fetchState_e;

   // Sequential PC; the 4-bit result wraps 15 -> 0 on its own.
   function automatic logic [PC_W-1:0] pcIncr(input logic [PC_W-1:0] pc);
      return pc + 1'b1;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-ROM read bus between the fetch unit and the ROM.
//   MemReq   : read request, held high while a read is outstanding
//   MemAddr  : read address, stable for the whole request
//   MemValid : one-cycle response strobe
//   MemData  : instruction word, valid in the MemValid cycle
// Modports: master = fetch unit, slave = ROM.
// -----------------------------------------------------------------------------
interface pc_fetch_unit_if;
   import cpu_pkg::*;

   logic               MemReq;
   logic [PC_W-1:0]    MemAddr;
   logic               MemValid;
   logic [INSTR_W-1:0] MemData;

   modport master (output MemReq, MemAddr, input MemValid, MemData);
   modport slave  (input MemReq, MemAddr, output MemValid, MemData);

endinterface

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program counter and its next-PC mux.
//   Clk, CLB        : clock, asynchronous active-low reset (PC -> 0)
//   IncPC, LoadPC   : update strobes; LoadPC has priority
//   SelPC           : jump-target select, 1 = immTarget, 0 = regTarget
//   immTarget       : IR operand field
//   regTarget       : register-file value
//   PC              : current program counter
//   pcNext          : value PC takes at the coming edge
// -----------------------------------------------------------------------------
module pc_register
   import cpu_pkg::*;
(
   input  logic              Clk,
   input  logic              CLB,
   input  logic              IncPC,
   input  logic              LoadPC,
   input  logic              SelPC,
   input  logic [DATA_W-1:0] immTarget,
   input  logic [DATA_W-1:0] regTarget,
   output logic [PC_W-1:0]   PC,
   output logic [PC_W-1:0]   pcNext
);

   always_comb begin
      pcNext = PC;
      if (LoadPC) begin
         pcNext = SelPC ? immTarget : regTarget;
      end else if (IncPC) begin
         pcNext = pcIncr(PC);
      end
   end

   always_ff @(posedge Clk or negedge CLB) begin
      if (!CLB) begin
         PC <= '0;
      end else begin
         PC <= pcNext;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Holds the PC, prefetches the instruction at the fetch address into a
// one-entry tagged buffer and transfers it into IR on controller request.
//   Clk, CLB          : clock, asynchronous active-low reset
//   LoadIR            : request IR <= instruction at PC
//   IncPC, LoadPC     : PC update strobes (LoadPC wins)
//   SelPC             : jump target, 1 = IR operand, 0 = RegData
//   RegData           : register-file jump target
//   memBus            : instruction-ROM read bus (master side)
//   Opcode, Operand   : IR[7:4] / IR[3:0], forced to 0 while IRValid = 0
//   PC                : current program counter
//   IRValid           : IR holds a fetched instruction
// -----------------------------------------------------------------------------
module pc_fetch_unit
   import cpu_pkg::*;
(
   input  logic                    Clk,
   input  logic                    CLB,
   input  logic                    LoadIR,
   input  logic                    IncPC,
   input  logic                    LoadPC,
   input  logic                    SelPC,
   input  logic [DATA_W-1:0]       RegData,
   pc_fetch_unit_if.master         memBus,
   output logic [3:0]              Opcode,
   output logic [3:0]              Operand,
   output logic [PC_W-1:0]         PC,
   output logic                    IRValid
);

   fetchState_e        state, stateNxt;
   logic [INSTR_W-1:0] ir;
   logic               irValid;
   logic [INSTR_W-1:0] bufData;
   logic [PC_W-1:0]    bufTag;
   logic               bufValid;
   logic               pending, pendingNxt;
   logic [PC_W-1:0]    loadAddr, loadAddrNxt;
   logic [PC_W-1:0]    reqAddr;
   logic [PC_W-1:0]    pcNext;
   logic [PC_W-1:0]    fetchAddr, fetchAddrNxt;
   logic               hit, irHit, fillOk;
   logic               irFromBuf, irFromMem;
   logic               launch, bufWrite, bufClear;

   pc_register uPc (
      .Clk       (Clk),
      .CLB       (CLB),
      .IncPC     (IncPC),
      .LoadPC    (LoadPC),
      .SelPC     (SelPC),
      .immTarget (ir[3:0]),
      .regTarget (RegData),
      .PC        (PC),
      .pcNext    (pcNext)
   );

   // An outstanding IR load redirects fetching to the address it asked for.
   assign fetchAddr = pending ? loadAddr : PC;
   assign hit       = bufValid && (bufTag == fetchAddr);
   // A new LoadIR always wants the pre-update PC, even while another is pending.
   assign irHit     = bufValid && (bufTag == PC);
   // Response is usable only if the address it was issued for is still wanted.
   assign fillOk    = (state == FETCH) && memBus.MemValid && (reqAddr == fetchAddr);

   // IR source selection; the newest LoadIR replaces any pending one.
   always_comb begin
      irFromBuf   = 1'b0;
      irFromMem   = 1'b0;
      pendingNxt  = pending;
      loadAddrNxt = loadAddr;
      if (LoadIR) begin
         if (irHit) begin
            irFromBuf = 1'b1;
         end else if (fillOk && (reqAddr == PC)) begin
            // Response for PC arrives on the request edge: take it directly.
            irFromMem = 1'b1;
         end else begin
            pendingNxt  = 1'b1;
            loadAddrNxt = PC;
         end
      end else if (pending) begin
         if (hit) begin
            irFromBuf = 1'b1;
         end else if (fillOk) begin
            irFromMem = 1'b1;
         end
      end
      if (irFromBuf || irFromMem) begin
         pendingNxt = 1'b0;
      end
   end

   // Prefetch FSM; launch re-latches the request address for the next FETCH cycle.
   always_comb begin
      stateNxt = state;
      launch   = 1'b0;
      bufWrite = 1'b0;
      bufClear = 1'b0;
      case (state)
         IDLE: begin
            stateNxt = FETCH;
            launch   = 1'b1;
         end
         FETCH: begin
            if (memBus.MemValid) begin
               if (fillOk && !irFromMem) begin
                  bufWrite = 1'b1;
                  stateNxt = FULL;
               end else begin
                  // Stale data, or data already consumed by IR: ask again.
                  launch = 1'b1;
               end
            end
         end
         FULL: begin
            if (irFromBuf || !hit) begin
               bufClear = 1'b1;
               stateNxt = FETCH;
               launch   = 1'b1;
            end
         end
         default: begin
            stateNxt = IDLE;
         end
      endcase
      fetchAddrNxt = pendingNxt ? loadAddrNxt : pcNext;
   end

   always_ff @(posedge Clk or negedge CLB) begin
      if (!CLB) begin
         state    <= IDLE;
         reqAddr  <= '0;
         ir       <= '0;
         irValid  <= 1'b0;
         bufData  <= '0;
         bufTag   <= '0;
         bufValid <= 1'b0;
         pending  <= 1'b0;
         loadAddr <= '0;
      end else begin
         state    <= stateNxt;
         pending  <= pendingNxt;
         loadAddr <= loadAddrNxt;
         if (launch) begin
            reqAddr <= fetchAddrNxt;
         end
         if (irFromBuf) begin
            ir      <= bufData;
            irValid <= 1'b1;
         end else if (irFromMem) begin
            ir      <= memBus.MemData;
            irValid <= 1'b1;
         end else if (LoadIR) begin
            irValid <= 1'b0;
         end
         if (bufWrite) begin
            bufValid <= 1'b1;
            bufTag   <= reqAddr;
            bufData  <= memBus.MemData;
         end else if (bufClear || irFromBuf) begin
            bufValid <= 1'b0;
         end
      end
   end

   assign memBus.MemReq  = (state == FETCH);
   assign memBus.MemAddr = reqAddr;
   assign IRValid        = irValid;
   assign Opcode         = irValid ? ir[7:4] : 4'b0000;
   assign Operand        = irValid ? ir[3:0] : 4'b0000;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Drives controller strobes, models the instruction ROM with a fixed response
// latency, and checks IR contents against a queue of expected instructions.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;
   import cpu_pkg::*;

   logic       Clk = 1'b0;
   logic       CLB = 1'b0;
   logic       LoadIR = 1'b0;
   logic       IncPC = 1'b0;
   logic       LoadPC = 1'b0;
   logic       SelPC = 1'b0;
   logic [3:0] RegData = 4'h0;
   logic [3:0] Opcode;
   logic [3:0] Operand;
   logic [3:0] PC;
   logic       IRValid;

   pc_fetch_unit_if memBus ();

   pc_fetch_unit dut (
      .Clk     (Clk),
      .CLB     (CLB),
      .LoadIR  (LoadIR),
      .IncPC   (IncPC),
      .LoadPC  (LoadPC),
      .SelPC   (SelPC),
      .RegData (RegData),
      .memBus  (memBus),
      .Opcode  (Opcode),
      .Operand (Operand),
      .PC      (PC),
      .IRValid (IRValid)
   );

   always #5 Clk = ~Clk;

   int         nChecks = 0;
   int         nFails  = 0;
   logic [7:0] rom [16];
   logic [7:0] expQ [$];
   logic [3:0] pcModel = 4'h0;

   // ROM model state
   int         memLat = 2;
   bit         memManual = 1'b0;
   bit         injectLate = 1'b0;
   bit         memBusy = 1'b0;
   logic [3:0] capAddr = 4'h0;
   logic [3:0] lastRespAddr = 4'hF;
   int         memCnt = 0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // ROM responder: capture a request, wait memLat cycles, answer for one cycle.
   initial begin
      memBus.MemValid = 1'b0;
      memBus.MemData  = 8'h00;
      forever begin
         @(posedge Clk);
         #2;
         if (!CLB) begin
            memBusy = 1'b0;
         end
         if (memManual) begin
            memBus.MemValid = injectLate;
            memBus.MemData  = injectLate ? 8'hFF : 8'h00;
         end else begin
            memBus.MemValid = 1'b0;
            memBus.MemData  = 8'h00;
            if (CLB) begin
               if (memBusy) begin
                  if (memCnt == 0) begin
                     checkEq("reqHeld", {memBus.MemReq, memBus.MemAddr}, {1'b1, capAddr});
                     memBus.MemValid = 1'b1;
                     memBus.MemData  = rom[capAddr];
                     lastRespAddr    = capAddr;
                     memBusy         = 1'b0;
                  end else begin
                     memCnt--;
                  end
               end else if (memBus.MemReq) begin
                  memBusy = 1'b1;
                  capAddr = memBus.MemAddr;
                  memCnt  = memLat;
               end
            end
         end
      end
   end

   task automatic loadPc(input logic [3:0] target);
      RegData = target;
      SelPC   = 1'b0;
      LoadPC  = 1'b1;
      tick();
      LoadPC  = 1'b0;
      pcModel = target;
   endtask

   // Wait until the buffer settles full (MemReq low two cycles running).
   task automatic waitFull(input string tag);
      int n = 0;
      int quiet = 0;
      while (quiet < 2 && n < 60) begin
         tick();
         n++;
         quiet = memBus.MemReq ? 0 : quiet + 1;
      end
      checkEq(tag, 32'(quiet >= 2), 1);
   endtask

   task automatic waitCapture(input logic [3:0] a);
      int n = 0;
      while (!(memBusy && capAddr == a) && n < 60) begin
         tick();
         n++;
      end
      checkEq("capture", 32'(memBusy && capAddr == a), 1);
   endtask

   task automatic doLoadIR(input bit expectHit, input bit withInc);
      logic [7:0] e;
      int n = 0;
      expQ.push_back(rom[pcModel]);
      LoadIR = 1'b1;
      IncPC  = withInc;
      tick();
      LoadIR = 1'b0;
      IncPC  = 1'b0;
      if (withInc) pcModel = pcModel + 4'd1;
      if (expectHit) checkEq("hitLatency", IRValid, 1);
      else checkEq("missIRValid", IRValid, 0);
      checkEq("pcAfterLoadIR", PC, pcModel);
      while (!IRValid && n < 60) begin
         checkEq("nopWhileInvalid", {Opcode, Operand}, 8'h00);
         tick();
         n++;
      end
      checkEq("irArrive", IRValid, 1);
      e = expQ.pop_front();
      checkEq("irWord", {Opcode, Operand}, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 8'h1A + 8'(i * 17);

      // Reset state
      tick();
      tick();
      checkEq("rstPC", PC, 0);
      checkEq("rstIRValid", IRValid, 0);
      checkEq("rstMemReq", memBus.MemReq, 0);
      checkEq("rstMemAddr", memBus.MemAddr, 0);
      checkEq("rstOpOperand", {Opcode, Operand}, 8'h00);

      // First fetch after reset release, then a buffer-hit IR load
      CLB = 1'b1;
      checkEq("idleMemReq", memBus.MemReq, 0);
      tick();
      checkEq("fetchMemReq", memBus.MemReq, 1);
      checkEq("fetchMemAddr", memBus.MemAddr, 0);
      waitFull("fullAfterReset");
      checkEq("firstFillAddr", lastRespAddr, 0);
      doLoadIR(1'b1, 1'b0);
      checkEq("opcode1A", Opcode, 4'b0001);
      checkEq("operand1A", Operand, 4'b1010);
      checkEq("pcUnchanged", PC, 0);

      // PC wrap 15 -> 0 and refetch of address 0
      loadPc(4'hF);
      checkEq("pcLoad15", PC, 15);
      IncPC = 1'b1;
      tick();
      IncPC = 1'b0;
      pcModel = 4'h0;
      checkEq("pcWrap", PC, 0);
      waitFull("fullAfterWrap");
      checkEq("wrapFillAddr", lastRespAddr, 0);

      // Jump to 7 while address 3 is in flight
      loadPc(4'h3);
      waitCapture(4'h3);
      loadPc(4'h7);
      waitFull("fullAfterJump");
      checkEq("jumpFillAddr", lastRespAddr, 7);
      checkEq("pcJump", PC, 7);
      doLoadIR(1'b1, 1'b0);

      // LoadPC beats IncPC; immediate target from IR operand (rom[15] = 8'h19)
      loadPc(4'hF);
      waitFull("fullAt15");
      doLoadIR(1'b1, 1'b0);
      RegData = 4'h3;
      SelPC   = 1'b1;
      LoadPC  = 1'b1;
      IncPC   = 1'b1;
      tick();
      LoadPC  = 1'b0;
      IncPC   = 1'b0;
      SelPC   = 1'b0;
      pcModel = 4'h9;
      checkEq("pcImmPriority", PC, 9);

      // LoadIR miss at PC=4 with IncPC in the same cycle
      loadPc(4'h4);
      doLoadIR(1'b0, 1'b1);
      checkEq("pcAfterMiss", PC, 5);
      waitFull("fullAfter5");
      checkEq("nextFillAddr", lastRespAddr, 5);

      // Newest LoadIR wins over an older pending one
      loadPc(4'h2);
      LoadIR = 1'b1;
      tick();
      LoadIR = 1'b0;
      checkEq("pendingIRValid", IRValid, 0);
      loadPc(4'h6);
      doLoadIR(1'b0, 1'b0);

      // Reset in the middle of a fetch; late response must be ignored
      loadPc(4'h8);
      waitCapture(4'h8);
      memManual  = 1'b1;
      injectLate = 1'b1;
      CLB = 1'b0;
      #1;
      checkEq("midRstPC", PC, 0);
      checkEq("midRstMemReq", memBus.MemReq, 0);
      checkEq("midRstMemAddr", memBus.MemAddr, 0);
      checkEq("midRstIRValid", IRValid, 0);
      checkEq("midRstOp", {Opcode, Operand}, 8'h00);
      tick();
      CLB = 1'b1;
      tick();
      injectLate = 1'b0;
      checkEq("lateIRValid", IRValid, 0);
      checkEq("lateMemReq", memBus.MemReq, 1);
      checkEq("lateMemAddr", memBus.MemAddr, 0);
      checkEq("latePC", PC, 0);
      memManual = 1'b0;
      pcModel   = 4'h0;
      waitFull("fullAfterRst");
      doLoadIR(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
